// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Purpose : Definitions shared by the read and write sides of the async FIFO.
//           These are the FWFT buffer depth, the buffered-level type and the
//           read-credit helper.
// Ports   : none (package)
// Config  : none
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  // Number of words the FWFT output stage can hold.
  localparam int unsigned FWFT_BUF_DEPTH = 2;

  // Buffered-word count, 0..FWFT_BUF_DEPTH.
  typedef logic [1:0] fwft_level_t;

  // This returns 1 when one more read can be issued. The words held, plus
  // the word in flight, minus the word leaving this cycle, must stay below
  // the buffer depth. A pop only happens with cnt >= 1, so the sum cannot go
  // negative.
  function automatic logic credit_ok(
    input fwft_level_t cnt,
    input logic        inflight,
    input logic        pop
  );
    logic [2:0] w_after;
    w_after = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return (w_after < 3'(FWFT_BUF_DEPTH));
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Purpose : This is a 2-entry in-order queue. The head register drives the
//           output word directly. The skid register holds the second word.
// Ports   : i_clk   clock
//           i_rst   synchronous active-high reset (clears the queue)
//           i_push  write i_data at the tail this cycle
//           i_data  word to write
//           i_pop   head is consumed this cycle
//           o_head  head word (holds its last value when empty)
//           o_cnt   words held, 0..2
//           o_valid head is valid (o_cnt != 0)
// Config  : none
// -----------------------------------------------------------------------------
module fifo_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int C_WIDTH = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [C_WIDTH-1:0] i_data,
  input  logic               i_pop,
  output logic [C_WIDTH-1:0] o_head,
  output fwft_level_t        o_cnt,
  output logic               o_valid
);

  logic [C_WIDTH-1:0] r_head;
  logic [C_WIDTH-1:0] r_skid;
  fwft_level_t        r_cnt;

  // Queue update. Head and skid change only when the queue occupancy requires it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_skid <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({i_push, i_pop})
            // The head leaves and the new word replaces it directly, so no bubble forms.
            2'b11: r_head <= i_data;
            2'b10: begin
              r_skid <= i_data;
              r_cnt  <= 2'd2;
            end
            2'b01: r_cnt <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          case ({i_push, i_pop})
            2'b11: begin
              r_head <= r_skid;
              r_skid <= i_data;
            end
            2'b01: begin
              r_head <= r_skid;
              r_cnt  <= 2'd1;
            end
            // A push while full cannot occur because the read credit prevents it.
            default: ;
          endcase
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_cnt   = r_cnt;
  assign o_valid = (r_cnt != 2'd0);

endmodule

// File: rtl/rd_fwft_stage_chk.sv
// -----------------------------------------------------------------------------
// rd_fwft_stage_chk
// Purpose : These are simulation-time invariants of the read FWFT stage. No
//           read is issued while the FIFO is empty. The buffer occupancy and
//           the outstanding-word count never exceed the buffer depth.
// Ports   : clk, rst       clock and synchronous active-high reset
//           rd_empty, rd_en read-pointer handshake
//           cnt, inflight   internal occupancy state
// Config  : none
// -----------------------------------------------------------------------------
module rd_fwft_stage_chk
  import async_fifo_pkg::*;
#(
  parameter int C_DEPTH_BITS = 10
) (
  input logic        clk,
  input logic        rst,
  input logic        rd_empty,
  input logic        rd_en,
  input fwft_level_t cnt,
  input logic        inflight
);

  // A FIFO needs at least one address bit.
  if (C_DEPTH_BITS < 1) begin : g_bad_depth
    $error("rd_fwft_stage: C_DEPTH_BITS must be >= 1");
  end

  // Reads are never requested from an empty FIFO.
  a_no_masked_read: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && rd_empty));

  // The buffer never overflows.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt <= 2'd2);

  // At most two words are outstanding. This counts the buffered words plus the word in flight.
  a_outstanding: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, cnt} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: rtl/rd_fwft_stage.sv
// -----------------------------------------------------------------------------
// rd_fwft_stage
// Purpose : This is the read-side first-word-fall-through stage of the async
//           FIFO, in the RD_CLK domain. It issues RD_EN to the read-pointer
//           block. It captures the registered RAM data one cycle later into a
//           2-entry buffer. It presents that buffer as a valid/ready stream.
// Ports   : RD_CLK    read clock
//           RD_RST    synchronous active-high reset
//           RD_EMPTY  empty flag from the read-pointer block
//           RD_EN     read request (combinational)
//           RD_DATA   RAM data, valid the cycle after RD_EN
//           M_VALID   output word valid
//           M_READY   downstream accept
//           M_DATA    output word
//           RD_LEVEL  buffered words 0..2
// Config  : When RD_FWFT_LEVEL_EN is defined, RD_LEVEL reports the buffer
//           count. Otherwise RD_LEVEL is tied to 0.
// -----------------------------------------------------------------------------
module rd_fwft_stage
  import async_fifo_pkg::*;
#(
  parameter int C_WIDTH      = 64,
  parameter int C_DEPTH_BITS = 10
) (
  input  logic               RD_CLK,
  input  logic               RD_RST,
  input  logic               RD_EMPTY,
  output logic               RD_EN,
  input  logic [C_WIDTH-1:0] RD_DATA,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic [C_WIDTH-1:0] M_DATA,
  output logic [1:0]         RD_LEVEL
);

  logic        r_inflight;
  logic        w_pop;
  logic        w_valid;
  fwft_level_t w_cnt;

  assign w_pop = w_valid & M_READY;

  // Read credit. A read is issued only when the FIFO is not empty and the
  // buffer will have room when the data arrives. The request is held low
  // during reset.
  always_comb begin
    RD_EN = 1'b0;
    if (!RD_RST && !RD_EMPTY) begin
      RD_EN = credit_ok(w_cnt, r_inflight, w_pop);
    end else begin
      RD_EN = 1'b0;
    end
  end

  // This flag marks that the RAM presents a requested word on RD_DATA this cycle.
  always_ff @(posedge RD_CLK) begin
    if (RD_RST) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= RD_EN;
    end
  end

  fifo_skid_buf #(
    .C_WIDTH (C_WIDTH)
  ) u_buf (
    .i_clk   (RD_CLK),
    .i_rst   (RD_RST),
    .i_push  (r_inflight),
    .i_data  (RD_DATA),
    .i_pop   (w_pop),
    .o_head  (M_DATA),
    .o_cnt   (w_cnt),
    .o_valid (w_valid)
  );

  assign M_VALID = w_valid;

`ifdef RD_FWFT_LEVEL_EN
  // The level is the buffer count register itself, so it updates together with cnt.
  assign RD_LEVEL = w_cnt;
`else
  assign RD_LEVEL = 2'd0;
`endif

  rd_fwft_stage_chk #(
    .C_DEPTH_BITS (C_DEPTH_BITS)
  ) u_chk (
    .clk      (RD_CLK),
    .rst      (RD_RST),
    .rd_empty (RD_EMPTY),
    .rd_en    (RD_EN),
    .cnt      (w_cnt),
    .inflight (r_inflight)
  );

endmodule
